// File: rtl/decoder_pulse_pkg.sv
// Shared types for the handshaked pulse/level decoder.
package decoder_pkg;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_PULSE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_pulse_dec.sv
// Combinational NUM_WIRE-way one-hot decoder with enable.
// Indices at or above NUM_WIRE produce all-zero.
module decoder_pulse_dec #(
  parameter int NUM_WIRE = 4,
  parameter int ADDR_W   = $clog2(NUM_WIRE)
) (
  input  logic                en_i,
  input  logic [ADDR_W-1:0]   a_i,
  output logic [NUM_WIRE-1:0] onehot_o
);

  for (genvar gi = 0; gi < NUM_WIRE; gi++) begin : g_dec
    assign onehot_o[gi] = en_i & (a_i == ADDR_W'(gi));
  end

endmodule

// File: rtl/decoder_pulse.sv
// Registered, handshaked one-hot decoder: LEVEL mode follows the input each
// cycle, PULSE mode holds the selected wire for PULSE_LEN cycles.
module decoder_pulse
  import decoder_pkg::*;
#(
  parameter int  NUM_WIRE  = 4,
  parameter int  PULSE_LEN = 4,
  localparam int ADDR_W    = $clog2(NUM_WIRE),
  localparam int CNT_W     = $clog2(PULSE_LEN + 1)
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                mode_i,
  input  logic [ADDR_W-1:0]   a_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  output logic [NUM_WIRE-1:0] d_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PULSE_LEN - 1);
  localparam logic [ADDR_W:0]   NUM_WIRE_L = (ADDR_W + 1)'(NUM_WIRE);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_WIRE-1:0] d_q, d_d;
  logic                err_q, err_d;

  logic [NUM_WIRE-1:0] onehot;
  logic                last_cycle;
  logic                xfer;
  logic                out_of_range;
  mode_e               mode;

  decoder_pulse_dec #(
    .NUM_WIRE (NUM_WIRE),
    .ADDR_W   (ADDR_W)
  ) u_dec (
    .en_i     (a_valid_i),
    .a_i      (a_i),
    .onehot_o (onehot)
  );

  // The final pulse cycle also accepts a new code so back-to-back pulses abut.
  assign last_cycle   = (state_q == ST_ACTIVE) && (cnt_q == CNT_LAST);
  assign a_ready_o    = (state_q == ST_IDLE) || last_cycle;
  assign xfer         = a_valid_i && a_ready_o;
  assign out_of_range = ({1'b0, a_i} >= NUM_WIRE_L);
  assign mode         = mode_e'(mode_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    err_d   = 1'b0;
    if (xfer) begin
      cnt_d = '0;
      if (out_of_range) begin
        state_d = ST_IDLE;
        d_d     = '0;
        err_d   = 1'b1;
      end else begin
        d_d     = onehot;
        state_d = (mode == MODE_PULSE) ? ST_ACTIVE : ST_IDLE;
      end
    end else if ((state_q == ST_ACTIVE) && !last_cycle) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      d_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      err_q   <= err_d;
    end
  end

  assign d_o    = d_q;
  assign busy_o = (state_q == ST_ACTIVE);
  assign err_o  = err_q;

endmodule

// File: tb/tb_decoder_pulse.sv
// Bench for decoder_pulse: three instances (4/3, 5/3, 4/1) share stimulus and
// are compared every cycle with a remaining-cycles reference model.
module tb_decoder_pulse;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       valid;
  logic       mode;
  logic [2:0] a;

  logic [3:0] d4, d1;
  logic [4:0] d5;
  logic       rdy [3];
  logic       busy [3];
  logic       err [3];
  logic [7:0] d_obs [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_pulse #(.NUM_WIRE(4), .PULSE_LEN(3)) u_dut4 (
    .clk_i(clk), .arst_ni(arst_n), .mode_i(mode), .a_i(a[1:0]), .a_valid_i(valid),
    .a_ready_o(rdy[0]), .d_o(d4), .busy_o(busy[0]), .err_o(err[0])
  );

  decoder_pulse #(.NUM_WIRE(5), .PULSE_LEN(3)) u_dut5 (
    .clk_i(clk), .arst_ni(arst_n), .mode_i(mode), .a_i(a), .a_valid_i(valid),
    .a_ready_o(rdy[1]), .d_o(d5), .busy_o(busy[1]), .err_o(err[1])
  );

  decoder_pulse #(.NUM_WIRE(4), .PULSE_LEN(1)) u_dut1 (
    .clk_i(clk), .arst_ni(arst_n), .mode_i(mode), .a_i(a[1:0]), .a_valid_i(valid),
    .a_ready_o(rdy[2]), .d_o(d1), .busy_o(busy[2]), .err_o(err[2])
  );

  assign d_obs[0] = {4'b0, d4};
  assign d_obs[1] = {3'b0, d5};
  assign d_obs[2] = {4'b0, d1};

  // Reference: rem counts the pulse cycles still to be shown, including the current one.
  typedef struct {
    logic [7:0] d;
    int         rem;
    bit         err;
  } mstate_t;

  mstate_t mdl [3];
  int      n_w [3]   = '{4, 5, 4};
  int      p_len [3] = '{3, 3, 1};

  function automatic mstate_t model_step(mstate_t s, int n, int pl, bit v, int addr, bit m);
    mstate_t r;
    r     = s;
    r.err = 1'b0;
    if (v && (s.rem <= 1)) begin
      if (addr >= n) begin
        r.d   = 8'h00;
        r.rem = 0;
        r.err = 1'b1;
      end else begin
        r.d   = 8'(1 << addr);
        r.rem = m ? pl : 0;
      end
    end else if (s.rem > 1) begin
      r.rem = s.rem - 1;
    end else begin
      r.rem = 0;
      r.d   = 8'h00;
    end
    return r;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!arst_n) mdl[i] <= '{8'h00, 0, 1'b0};
      else mdl[i] <= model_step(mdl[i], n_w[i], p_len[i], valid,
                                (i == 1) ? int'(a) : int'(a[1:0]), mode);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d_obs[i] !== mdl[i].d) begin
        errors++;
        $display("FAIL model_d dut%0d @%0t: got %b want %b", i, $time, d_obs[i], mdl[i].d);
      end
      checks++;
      if (rdy[i] !== (mdl[i].rem <= 1)) begin
        errors++;
        $display("FAIL model_ready dut%0d @%0t: got %b want %b", i, $time, rdy[i], mdl[i].rem <= 1);
      end
      checks++;
      if (busy[i] !== (mdl[i].rem > 0)) begin
        errors++;
        $display("FAIL model_busy dut%0d @%0t: got %b want %b", i, $time, busy[i], mdl[i].rem > 0);
      end
      checks++;
      if (err[i] !== mdl[i].err) begin
        errors++;
        $display("FAIL model_err dut%0d @%0t: got %b want %b", i, $time, err[i], mdl[i].err);
      end
      checks++;
      if ($isunknown(d_obs[i]) || !$onehot0(d_obs[i])) begin
        errors++;
        $display("FAIL onehot0 dut%0d @%0t: got %b want at most one bit set", i, $time, d_obs[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    valid  = 1'b0;
    mode   = 1'b0;
    a      = 3'd0;
    #7;
    checks++;
    if (d4 !== 4'b0000 || busy[0] !== 1'b0 || rdy[0] !== 1'b1 || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL por_state: got d=%b busy=%b rdy=%b err=%b want d=0000 busy=0 rdy=1 err=0",
               d4, busy[0], rdy[0], err[0]);
    end
    #5;
    arst_n = 1'b1;
    tick();
    a = 3'd1; mode = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    checks++;
    if (d4 !== 4'b0010 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_active: got d=%b busy=%b want d=0010 busy=1", d4, busy[0]);
    end
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (d4 !== 4'b0000 || busy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got d=%b busy=%b rdy=%b want d=0000 busy=0 rdy=1",
               d4, busy[0], rdy[0]);
    end
    #3;
    arst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_level();
    a = 3'd2; mode = 1'b0; valid = 1'b1;
    tick();
    checks++;
    if (d4 !== 4'b0100 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL level_d: got d=%b busy=%b want d=0100 busy=0", d4, busy[0]);
    end
    valid = 1'b0;
    tick();
    checks++;
    if (d4 !== 4'b0000) begin
      errors++;
      $display("FAIL level_clear: got %b want 0000", d4);
    end
    idle(2);
  endtask

  task automatic test_pulse();
    logic [3:0] exp_d [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic       exp_r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    a = 3'd1; mode = 1'b1; valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      valid = 1'b0;
      checks++;
      if (d4 !== exp_d[k] || rdy[0] !== exp_r[k] || busy[0] !== exp_b[k]) begin
        errors++;
        $display("FAIL pulse_t%0d: got d=%b rdy=%b busy=%b want d=%b rdy=%b busy=%b",
                 k + 1, d4, rdy[0], busy[0], exp_d[k], exp_r[k], exp_b[k]);
      end
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    a = 3'd1; mode = 1'b1; valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) a = 3'd3;
      if (k == 3) valid = 1'b0;
      checks++;
      if (d4 !== exp_d[k]) begin
        errors++;
        $display("FAIL b2b_t%0d: got %b want %b", k + 1, d4, exp_d[k]);
      end
    end
    idle(2);
  endtask

  task automatic test_out_of_range();
    a = 3'd6; mode = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if (err[1] !== 1'b1 || d5 !== 5'b00000 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL oor_first: got err=%b d=%b busy=%b want err=1 d=00000 busy=0",
               err[1], d5, busy[1]);
    end
    tick();
    checks++;
    if (err[1] !== 1'b0 || d5 !== 5'b00000) begin
      errors++;
      $display("FAIL oor_second: got err=%b d=%b want err=0 d=00000", err[1], d5);
    end
    a = 3'd4; mode = 1'b0; valid = 1'b1;
    tick();
    checks++;
    if (err[1] !== 1'b0 || d5 !== 5'b10000) begin
      errors++;
      $display("FAIL top_wire: got err=%b d=%b want err=0 d=10000", err[1], d5);
    end
    idle(4);
  endtask

  task automatic test_mode_change();
    logic [3:0] exp_d [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
    a = 3'd2; mode = 1'b1; valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      valid = 1'b0;
      mode  = 1'b0;
      checks++;
      if (d4 !== exp_d[k]) begin
        errors++;
        $display("FAIL mode_change_t%0d: got %b want %b", k + 1, d4, exp_d[k]);
      end
    end
    idle(2);
  endtask

  task automatic test_pulse_len1();
    a = 3'd3; mode = 1'b1; valid = 1'b1;
    tick();
    checks++;
    if (d1 !== 4'b1000 || busy[2] !== 1'b1 || rdy[2] !== 1'b1) begin
      errors++;
      $display("FAIL pl1_first: got d=%b busy=%b rdy=%b want d=1000 busy=1 rdy=1",
               d1, busy[2], rdy[2]);
    end
    a = 3'd0;
    tick();
    checks++;
    if (d1 !== 4'b0001 || busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL pl1_b2b: got d=%b busy=%b want d=0001 busy=1", d1, busy[2]);
    end
    valid = 1'b0;
    tick();
    checks++;
    if (d1 !== 4'b0000 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL pl1_end: got d=%b busy=%b want d=0000 busy=0", d1, busy[2]);
    end
    idle(3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      valid = ($urandom_range(0, 9) < 7);
      a     = 3'($urandom_range(0, 7));
      mode  = 1'($urandom_range(0, 1));
      tick();
      if (err[1] === 1'b1) begin
        checks++;
        if (d5 !== 5'b00000 || busy[1] !== 1'b0) begin
          errors++;
          $display("FAIL rand_err_d: got d=%b busy=%b want d=00000 busy=0", d5, busy[1]);
        end
      end
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_level();
    test_pulse();
    test_back_to_back();
    test_out_of_range();
    test_mode_change();
    test_pulse_len1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
